// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a clk-derived bit clock and a one-pair holding buffer.
// bclk is produced by a half-period divider. Outputs change only on bclk falling
// edges. Each frame sends the left sample, then the right sample, MSB first.
// ws leads the data by one bit.
// Optional macro I2S_TX_MUTE_ON_UNDERRUN_EN: when it is defined, an underrun frame
// is sent as zeros. When it is not defined, an underrun frame repeats the last pair.
module i2s_tx #(
  parameter int DIV_HALF = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] audio_l,
  input  logic [SAMPLE_W-1:0] audio_r,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bclk,
  output logic                ws,
  output logic                sdata,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int DIV_W   = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0]  BC_WS_HI = BC_W'(SAMPLE_W - 1);

  logic [DIV_W-1:0]    r_div;
  logic                r_bclk;
  logic [BC_W-1:0]     r_bit_cnt;
  logic [FRAME_W-1:0]  r_shreg;
  logic                r_ws;
  logic                r_sdata;
  logic [SAMPLE_W-1:0] r_hold_l;
  logic [SAMPLE_W-1:0] r_hold_r;
  logic                r_hold_full;

  logic                w_div_wrap;
  logic                w_fall;
  logic                w_load;
  logic                w_ready;
  logic                w_accept;
  logic [BC_W-1:0]     w_bit_nxt;
  logic [BC_W-1:0]     w_bit_idx;
  logic [FRAME_W-1:0]  w_reload;
  logic [FRAME_W-1:0]  w_frame;

  // Decode the divider and bit-position events and the input handshake.
  always_comb begin
    w_div_wrap = (r_div == DIV_LAST);
    // Gating with rst keeps a reset cycle from counting as a falling edge or a load.
    w_fall     = !rst && w_div_wrap && r_bclk;
    w_load     = w_fall && (r_bit_cnt == BC_LAST);
    // in_ready passes straight through on a load cycle, because the hold slot drains that cycle.
    w_ready    = rst || !r_hold_full || w_load;
    w_accept   = !rst && in_valid && w_ready;
    w_bit_nxt  = w_load ? '0 : r_bit_cnt + BC_W'(1);
    w_bit_idx  = BC_LAST - w_bit_nxt;
  end

  // Select the next frame's content. A fresh pair is used if one is held; otherwise the underrun policy applies.
  always_comb begin
    w_reload = r_shreg;
    if (r_hold_full) begin
      w_reload = {r_hold_l, r_hold_r};
    end else begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
      w_reload = '0;
`else
      w_reload = r_shreg;
`endif
    end
    w_frame = w_load ? w_reload : r_shreg;
  end

  // Half-period divider. bclk toggles each time the divider wraps, which gives an exact 50% duty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_div_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Serializer. On each bclk falling edge: advance the bit position, present that frame bit, and update ws.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Parking at the last bit position makes the first falling edge a frame load.
      r_bit_cnt <= BC_LAST;
      r_shreg   <= '0;
      r_sdata   <= 1'b0;
      r_ws      <= 1'b0;
    end else if (w_fall) begin
      r_bit_cnt <= w_bit_nxt;
      // The shift register holds the whole pair unshifted. This lets an underrun repeat the last pair.
      r_sdata   <= w_frame[w_bit_idx];
      if (w_load) r_shreg <= w_reload;
      if (w_bit_nxt == BC_WS_HI)     r_ws <= 1'b1;
      else if (w_bit_nxt == BC_LAST) r_ws <= 1'b0;
    end
  end

  // Single-entry holding buffer between the source and the serializer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (w_accept) begin
      // This branch also covers a load that accepts a new pair in the same cycle: the slot stays full.
      r_hold_l    <= audio_l;
      r_hold_r    <= audio_r;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  assign in_ready = w_ready;
  assign bclk     = r_bclk;
  assign ws       = r_ws;
  assign sdata    = r_sdata;
  assign underrun = w_load && !r_hold_full;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized self-checking bench for i2s_tx. It uses a frame-level reference model
// that works from cycle counts since reset and a queue of pending pairs.
module tb_i2s_tx;

  localparam int D         = 4;
  localparam int SW        = 16;
  localparam int FW        = 2 * SW;
  localparam int HALF_PER  = 2 * D;
  localparam int FRAME_CYC = FW * HALF_PER;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] audio_l = '0;
  logic [SW-1:0] audio_r = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, bclk, ws, sdata, underrun;

  always #5 clk = ~clk;

  i2s_tx #(.DIV_HALF(D), .SAMPLE_W(SW)) dut (
    .clk(clk), .rst(rst), .audio_l(audio_l), .audio_r(audio_r),
    .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .ws(ws),
    .sdata(sdata), .underrun(underrun)
  );

  int          n_vec = 0;
  int          n_err = 0;
  // model: pc = index of the next non-reset posedge, pend = buffered pairs, cur = frame on the wire
  int          pc = 0;
  logic [31:0] pend[$];
  logic [31:0] cur = '0;
  // source side
  logic [31:0] src_q[$];
  bit          src_en = 1'b0;
  // observation logs
  logic        sd_hist[$];
  logic        ws_hist[$];
  int          acc_log[$];
  int          und_cnt = 0;
  int          low_run = 0;
  int          max_low = 0;
  logic        prev_bclk = 1'b0;

  function automatic bit is_load(input int p);
    return (p >= HALF_PER - 1) && (((p - (HALF_PER - 1)) % FRAME_CYC) == 0);
  endfunction

  // One clk cycle. The task is entered at a negedge and returns at the next negedge.
  task automatic step(input bit do_rst);
    bit          exp_rdy, exp_und, acc, ld;
    logic [31:0] w;
    int          falls, k;
    logic        e_bclk, e_ws, e_sd;
    rst      = do_rst;
    in_valid = src_en && (src_q.size() > 0);
    if (in_valid) w = src_q[0]; else w = $urandom;
    audio_l  = w[31:16];
    audio_r  = w[15:0];
    #1;
    ld      = !do_rst && is_load(pc);
    exp_rdy = do_rst || (pend.size() == 0) || ld;
    exp_und = ld && (pend.size() == 0);
    n_vec++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready pc=%0d rst=%0b got %b want %b", pc, do_rst, in_ready, exp_rdy);
    end
    n_vec++;
    if (underrun !== exp_und) begin
      n_err++;
      $display("FAIL underrun pc=%0d rst=%0b got %b want %b", pc, do_rst, underrun, exp_und);
    end
    if (underrun === 1'b1) und_cnt++;
    if (in_ready === 1'b0) begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end else begin
      low_run = 0;
    end
    acc = !do_rst && in_valid && exp_rdy;
    if (!do_rst && in_valid && in_ready === 1'b1) acc_log.push_back(pc);
    @(posedge clk);
    if (do_rst) begin
      pc = 0;
      pend.delete();
      cur = '0;
    end else begin
      if (ld) begin
        if (pend.size() > 0) cur = pend.pop_front();
        else if (MUTE)       cur = '0;
      end
      if (acc) pend.push_back(src_q.pop_front());
      pc++;
    end
    @(negedge clk);
    if (do_rst) begin
      e_bclk = 1'b0; e_ws = 1'b0; e_sd = 1'b0;
    end else begin
      e_bclk = ((pc / D) % 2) == 1;
      falls  = pc / HALF_PER;
      if (falls == 0) begin
        e_ws = 1'b0; e_sd = 1'b0;
      end else begin
        k    = (falls - 1) % FW;
        e_sd = cur[FW-1-k];
        e_ws = (k >= SW - 1) && (k < FW - 1);
      end
    end
    n_vec++;
    if (bclk !== e_bclk) begin
      n_err++;
      $display("FAIL bclk pc=%0d got %b want %b", pc, bclk, e_bclk);
    end
    n_vec++;
    if (ws !== e_ws) begin
      n_err++;
      $display("FAIL ws pc=%0d got %b want %b", pc, ws, e_ws);
    end
    n_vec++;
    if (sdata !== e_sd) begin
      n_err++;
      $display("FAIL sdata pc=%0d got %b want %b", pc, sdata, e_sd);
    end
    if (!do_rst && prev_bclk === 1'b1 && bclk === 1'b0) begin
      sd_hist.push_back(sdata);
      ws_hist.push_back(ws);
    end
    prev_bclk = do_rst ? 1'b0 : bclk;
  endtask

  task automatic do_reset(input int n);
    src_en = 1'b0;
    src_q.delete();
    for (int i = 0; i < n; i++) step(1'b1);
    sd_hist.delete();
    ws_hist.delete();
    acc_log.delete();
    und_cnt = 0;
    max_low = 0;
    low_run = 0;
  endtask

  function automatic logic [31:0] hist_word(input int base);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v = {v[30:0], sd_hist[base+i]};
    return v;
  endfunction

  task automatic test_reset;
    int first_rise;
    first_rise = -1;
    do_reset(3);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      if (bclk === 1'b1 && first_rise < 0) first_rise = i;
    end
    n_vec++;
    if (first_rise !== 4) begin
      n_err++;
      $display("FAIL first_bclk_rise got %0d want 4", first_rise);
    end
  endtask

  task automatic test_single;
    logic [31:0] got;
    do_reset(2);
    src_q.push_back(32'hA5C3_0F01);
    src_en = 1'b1;
    for (int i = 0; i < HALF_PER + FRAME_CYC; i++) step(1'b0);
    n_vec++;
    if (sd_hist.size() < 32) begin
      n_err++;
      $display("FAIL single_bits got %0d falls want >=32", sd_hist.size());
    end else begin
      got = hist_word(0);
      if (got !== 32'hA5C3_0F01) begin
        n_err++;
        $display("FAIL single_frame got %h want a5c30f01", got);
      end
      n_vec++;
      if (ws_hist[14] !== 1'b0 || ws_hist[15] !== 1'b1 || ws_hist[30] !== 1'b1 || ws_hist[31] !== 1'b0) begin
        n_err++;
        $display("FAIL single_ws got k14..15=%b%b k30..31=%b%b want 01 10",
                 ws_hist[14], ws_hist[15], ws_hist[30], ws_hist[31]);
      end
    end
  endtask

  task automatic test_streaming;
    do_reset(2);
    src_en = 1'b1;
    for (int c = 0; c < 6 * FRAME_CYC + HALF_PER; c++) begin
      if (c % FRAME_CYC == 0) src_q.push_back($urandom);
      step(1'b0);
    end
    n_vec++;
    if (und_cnt !== 0) begin
      n_err++;
      $display("FAIL stream_underruns got %0d want 0", und_cnt);
    end
    n_vec++;
    if (max_low >= FRAME_CYC) begin
      n_err++;
      $display("FAIL stream_ready_low got %0d cycles want <%0d", max_low, FRAME_CYC);
    end
  endtask

  task automatic test_underrun;
    logic [31:0] got, want;
    do_reset(2);
    src_q.push_back(32'h1234_8000);
    src_en = 1'b1;
    for (int i = 0; i < 2 * FRAME_CYC + HALF_PER; i++) step(1'b0);
    n_vec++;
    if (und_cnt !== 2) begin
      n_err++;
      $display("FAIL underrun_pulses got %0d want 2", und_cnt);
    end
    want = MUTE ? 32'h0 : 32'h1234_8000;
    n_vec++;
    if (sd_hist.size() < 64) begin
      n_err++;
      $display("FAIL underrun_bits got %0d falls want >=64", sd_hist.size());
    end else begin
      got = hist_word(32);
      if (got !== want) begin
        n_err++;
        $display("FAIL underrun_frame got %h want %h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] p[3];
    logic [31:0] got;
    int          want_acc[3];
    want_acc = '{0, HALF_PER - 1, HALF_PER - 1 + FRAME_CYC};
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      do p[i] = $urandom;
      while ((i > 0 && p[i] == p[i-1]) || (i == 2 && p[2] == p[0]));
      src_q.push_back(p[i]);
    end
    src_en = 1'b1;
    for (int i = 0; i < 3 * FRAME_CYC + HALF_PER; i++) step(1'b0);
    n_vec++;
    if (acc_log.size() != 3) begin
      n_err++;
      $display("FAIL b2b_accepts got %0d want 3", acc_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (acc_log[i] != want_acc[i]) begin
          n_err++;
          $display("FAIL b2b_accept_cycle[%0d] got %0d want %0d", i, acc_log[i], want_acc[i]);
        end
      end
    end
    for (int f = 0; f < 3; f++) begin
      n_vec++;
      if (sd_hist.size() < 32 * (f + 1)) begin
        n_err++;
        $display("FAIL b2b_bits frame %0d got %0d falls", f, sd_hist.size());
      end else begin
        got = hist_word(32 * f);
        if (got !== p[f]) begin
          n_err++;
          $display("FAIL b2b_frame[%0d] got %h want %h", f, got, p[f]);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] got;
    do_reset(2);
    src_q.push_back($urandom);
    src_en = 1'b1;
    for (int i = 0; i < 21 * HALF_PER; i++) step(1'b0);
    src_q.push_back($urandom | 32'h8000_0001);
    step(1'b0);
    step(1'b0);
    // step(1) checks that the outputs reach their reset values one cycle after rst is asserted
    do_reset(1);
    for (int i = 0; i < FRAME_CYC + HALF_PER; i++) step(1'b0);
    n_vec++;
    if (und_cnt !== 2) begin
      n_err++;
      $display("FAIL midrst_underruns got %0d want 2", und_cnt);
    end
    n_vec++;
    if (sd_hist.size() < 32) begin
      n_err++;
      $display("FAIL midrst_bits got %0d falls want >=32", sd_hist.size());
    end else begin
      got = hist_word(0);
      if (got !== 32'h0) begin
        n_err++;
        $display("FAIL midrst_frame got %h want 00000000", got);
      end
    end
  endtask

  task automatic test_random;
    do_reset(2);
    for (int i = 0; i < 1600; i++) begin
      src_en = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 2 && $urandom_range(0, 199) == 0) src_q.push_back($urandom);
      step(1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_streaming;
    test_underrun;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DIV_HALF, default 4: number of clk cycles per bclk half-period, valid range 2..255.
REQ-002 SHALL have parameter SAMPLE_W, default 16: bits per channel sample; frame length is 2*SAMPLE_W bclk periods.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-005 audio_l  input  SAMPLE_W  left sample, two's complement.
REQ-006 audio_r  input  SAMPLE_W  right sample, two's complement.
REQ-007 in_valid  input  1  audio_l/audio_r pair is valid.
REQ-008 in_ready  output  1  block accepts the pair this cycle.
REQ-009 bclk  output  1  I2S bit clock, registered.
REQ-010 ws  output  1  I2S word select: 0 = left, 1 = right; registered.
REQ-011 sdata  output  1  I2S serial data, MSB first; registered.
REQ-012 underrun  output  1  one-cycle pulse when a frame starts with no fresh sample.

Function
REQ-013 SHALL divide clk with a counter 0..DIV_HALF-1; bclk toggles when the counter wraps; bclk duty cycle is exactly 50%.
REQ-014 Falling-edge event = the clk cycle in which bclk is driven 1->0; all sdata/ws/bit_cnt updates occur only on falling-edge events.
REQ-015 bit_cnt, 0..2*SAMPLE_W-1, SHALL advance on each falling-edge event and wrap from 2*SAMPLE_W-1 to 0.
REQ-016 On entering bit_cnt k: sdata = frame bit (2*SAMPLE_W-1-k) of the shift register {L,R}; left MSB at k=0, right MSB at k=SAMPLE_W.
REQ-017 ws SHALL be 1 on entering k=SAMPLE_W-1 and 0 on entering k=2*SAMPLE_W-1 (standard I2S one-bit lead); it holds otherwise.
REQ-018 A holding register (hold_l, hold_r, hold_full) SHALL capture the pair when in_valid && in_ready; hold_full is then set.
REQ-019 in_ready = !hold_full || load_now, where load_now = the falling-edge event wrapping bit_cnt to 0 (combinational pass-through is allowed).
REQ-020 On load_now with hold_full: the shift register takes {hold_l, hold_r}, and hold_full clears unless a new pair is accepted in the same cycle, in which case the new pair is held and hold_full stays 1.
REQ-021 On load_now without hold_full: underrun pulses high for exactly that cycle; the shift register reload follows REQ-033.
REQ-022 Latency: a pair accepted at any point of frame N SHALL be serialized in frame N+1; the left MSB appears on the load_now cycle.
REQ-023 Only one pair is buffered; a second in_valid while hold_full and not load_now SHALL see in_ready=0 and is not lost (the source holds it).
REQ-024 in_valid without in_ready SHALL have no effect; audio_* are ignored when in_valid=0.

Reset
REQ-025 During rst: bclk=0, ws=0, sdata=0, underrun=0, in_ready=1.
REQ-026 Reset SHALL clear the divider counter, the shift register and hold_full, and set bit_cnt=2*SAMPLE_W-1, so the first falling-edge event (2*DIV_HALF cycles after rst deasserts) is a load_now.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately; no partial sample is replayed and the held sample is discarded.
REQ-028 rst has priority over every other input.

Configuration
REQ-029 The macro I2S_TX_MUTE_ON_UNDERRUN_EN selects the underrun behaviour.
REQ-030 With the macro defined: on underrun, the shift register loads all zeros (mute).
REQ-031 Without the macro: on underrun, the shift register reloads the last transmitted pair (sample repeat); after reset the last pair is zero.
REQ-032 underrun pulse generation SHALL be identical in both builds.
REQ-033 The shift-register reload on underrun SHALL follow REQ-030 or REQ-031.

Verification
REQ-034 Reset: hold rst 3 cycles -> bclk=ws=sdata=underrun=0, in_ready=1; first bclk rise 4 cycles after release (DIV_HALF=4).
REQ-035 Single pair: L=16'hA5C3, R=16'h0F01 accepted before the first load -> sdata stream over the frame equals A5C3 then 0F01 MSB first; ws changes at k=15 and k=31.
REQ-036 Streaming: a new pair is offered every 256 clk (DIV_HALF=4, SAMPLE_W=16) -> no underrun pulse and in_ready never stuck low.
REQ-037 Underrun: send 16'h1234/16'h8000, then nothing -> next frame underrun=1 for one cycle; sdata all zeros with the macro, 1234/8000 repeated without it.
REQ-038 Backpressure: in_valid held high with 3 distinct pairs -> 1 accepted at once, 1 held, each subsequent pair accepted only on a load_now cycle; all pairs are serialized in order.
REQ-039 Mid-frame reset: rst at bit_cnt=20 -> outputs reach reset values the next cycle; the following frame starts with a load_now and an underrun pulse.
